// File: rtl/ad9911_pkg.sv
// ad9911_pkg: register map, field positions and state encodings shared by the AD9911 config sequencer
package ad9911_pkg;
  localparam logic [7:0] ADDR_CSR   = 8'h00;
  localparam logic [7:0] ADDR_FR1   = 8'h01;
  localparam logic [7:0] ADDR_CFR   = 8'h03;
  localparam logic [7:0] ADDR_CTW0  = 8'h04;
  localparam logic [7:0] ADDR_CPOW0 = 8'h05;
  localparam logic [7:0] ADDR_ACR   = 8'h06;
  localparam int ACR_MULT_EN_BIT = 12;
  localparam int FR1_VCO_BIT     = 23;
  localparam int FR1_PLL_LSB     = 18;
  typedef enum logic [2:0] {INIT, IDLE, PICK, XFER, UPD, FIN} cfg_state_t;
  typedef enum logic [2:0] {HS_IDLE, WAIT_IDLE, ISSUE, WAIT_START, WAIT_END} hs_state_t;
  function automatic logic [31:0] fr1_word(input logic vco, input logic [4:0] pll);
    fr1_word = (32'(vco) << FR1_VCO_BIT) | (32'(pll) << FR1_PLL_LSB);
  endfunction
  function automatic logic [31:0] acr_word(input logic [9:0] asf);
    acr_word = (32'd1 << ACR_MULT_EN_BIT) | 32'(asf);
  endfunction
endpackage

// File: rtl/ad9911_handshake_timer.sv
// ad9911_handshake_timer: one TR/OVER handshake with the serial writer, bounded by a per-phase timeout
module ad9911_handshake_timer
  import ad9911_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic CLK,
  input  logic RESET,
  input  logic start,
  input  logic wr_over,
  output logic wr_tr,
  output logic done,
  output logic timeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  hs_state_t st, nxt;
  logic [CW-1:0] cnt;
  logic expired, met;
  // state register; the counter restarts whenever the phase changes
  always_ff @(posedge CLK)
    if (RESET) begin
      st <= HS_IDLE;
      cnt <= '0;
    end else begin
      st <= nxt;
      cnt <= (st != nxt) ? '0 : cnt + 1'b1;
    end
  // next phase: each wait either sees its writer condition or gives up after the budget
  always_comb begin
    expired = cnt == TO_LAST;
    met = (st == WAIT_START) ? !wr_over : wr_over;
    nxt = st;
    case (st)
      HS_IDLE:    nxt = start ? WAIT_IDLE : HS_IDLE;
      WAIT_IDLE:  nxt = met ? ISSUE : expired ? HS_IDLE : WAIT_IDLE;
      ISSUE:      nxt = WAIT_START;
      WAIT_START: nxt = met ? WAIT_END : expired ? HS_IDLE : WAIT_START;
      WAIT_END:   nxt = (met || expired) ? HS_IDLE : WAIT_END;
      default:    nxt = HS_IDLE;
    endcase
  end
  // strobes toward the writer and the sequencer
  always_comb begin
    wr_tr = st == ISSUE;
    done = st == WAIT_END && wr_over;
    timeout = (st == WAIT_IDLE || st == WAIT_START || st == WAIT_END) && !met && expired;
  end
endmodule

// File: rtl/ad9911_channel_config_seq.sv
// ad9911_channel_config_seq: programs FR1 at power-up, then turns channel requests into AD9911 register writes
module ad9911_channel_config_seq
  import ad9911_pkg::*;
#(
  parameter int PLL_MUL        = 20,
  parameter int VCO_HIGH       = 1,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int UPDATE_CYCLES  = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CFG_VALID,
  output logic        CFG_READY,
  input  logic [3:0]  CFG_CHAN,
  input  logic [2:0]  CFG_SEL,
  input  logic [31:0] CFG_FTW,
  input  logic [13:0] CFG_POW,
  input  logic [9:0]  CFG_ASF,
  output logic        WR_TR,
  output logic [7:0]  WR_ADDR,
  output logic [31:0] WR_DATA,
  input  logic        WR_OVER,
  output logic        IO_UPDATE,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);
  localparam int UW = $clog2(UPDATE_CYCLES + 1);
  localparam logic [UW-1:0] UPD_LAST = UW'(UPDATE_CYCLES - 1);
  cfg_state_t st, nxt;
  logic boot, quiet, acc, hs_start, hs_done, hs_to;
  logic [3:0] pend, pick_bit, chan;
  logic [31:0] ftw, pick_data;
  logic [13:0] pow;
  logic [9:0] asf;
  logic [7:0] pick_addr;
  logic [UW-1:0] upd_cnt;
  ad9911_handshake_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_hs (
    .CLK(CLK),
    .RESET(RESET),
    .start(hs_start),
    .wr_over(WR_OVER),
    .wr_tr(WR_TR),
    .done(hs_done),
    .timeout(hs_to)
  );
  // sequencer state register
  always_ff @(posedge CLK)
    if (RESET) st <= INIT;
    else st <= nxt;
  // next state: a timeout abandons the request (or restarts power-up), an empty request skips IO_UPDATE
  always_comb begin
    nxt = st;
    case (st)
      INIT:    nxt = XFER;
      IDLE:    nxt = acc ? PICK : IDLE;
      PICK:    nxt = |pend ? XFER : quiet ? FIN : UPD;
      XFER:    nxt = hs_to ? (boot ? INIT : FIN) : hs_done ? (boot ? UPD : PICK) : XFER;
      UPD:     nxt = (upd_cnt == UPD_LAST) ? (boot ? IDLE : FIN) : UPD;
      FIN:     nxt = IDLE;
      default: nxt = INIT;
    endcase
  end
  // state-decoded outputs and handshake kick-off
  always_comb begin
    CFG_READY = st == IDLE;
    BUSY = st != IDLE;
    IO_UPDATE = st == UPD;
    DONE = st == FIN;
    acc = CFG_VALID && st == IDLE;
    hs_start = st == INIT || (st == PICK && |pend);
  end
  // lowest pending bit wins, giving the order CSR, CTW0, CPOW0, ACR
  always_comb begin
    pick_bit = pend & (~pend + 4'd1);
    pick_addr = pick_bit[0] ? ADDR_CSR : pick_bit[1] ? ADDR_CTW0 : pick_bit[2] ? ADDR_CPOW0 : ADDR_ACR;
    pick_data = pick_bit[0] ? {24'b0, chan, 4'b0000} : pick_bit[1] ? ftw : pick_bit[2] ? {18'b0, pow} : acr_word(asf);
  end
  // request capture, write list bookkeeping and writer address/data, held from selection until the frame ends
  always_ff @(posedge CLK)
    if (RESET) begin
      boot <= 1'b1;
      quiet <= 1'b0;
      ERR <= 1'b0;
      pend <= '0;
      chan <= '0;
      ftw <= '0;
      pow <= '0;
      asf <= '0;
      WR_ADDR <= '0;
      WR_DATA <= '0;
      upd_cnt <= '0;
    end else begin
      upd_cnt <= (st == UPD) ? upd_cnt + 1'b1 : '0;
      if (st == INIT) begin
        WR_ADDR <= ADDR_FR1;
        WR_DATA <= fr1_word(1'(VCO_HIGH), 5'(PLL_MUL));
      end
      if (acc) begin
        ERR <= 1'b0;
        chan <= CFG_CHAN;
        ftw <= CFG_FTW;
        pow <= CFG_POW;
        asf <= CFG_ASF;
        quiet <= CFG_CHAN == 4'd0 || CFG_SEL == 3'd0;
        pend <= (CFG_CHAN == 4'd0 || CFG_SEL == 3'd0) ? 4'd0 : {CFG_SEL, 1'b1};
      end
      if (st == PICK && |pend) begin
        WR_ADDR <= pick_addr;
        WR_DATA <= pick_data;
        pend <= pend & ~pick_bit;
      end
      if (hs_to) begin
        ERR <= 1'b1;
        pend <= '0;
      end
      if (st == UPD && boot && upd_cnt == UPD_LAST) boot <= 1'b0;
    end
endmodule

// File: tb/tb_ad9911_channel_config_seq.sv
// tb_ad9911_channel_config_seq: scoreboard bench with a writer model and a request-level reference model
module tb_ad9911_channel_config_seq;
  localparam int TIMEOUT = 1023;
  typedef struct {
    int kind;
    logic [7:0] addr;
    logic [31:0] data;
    int when;
    int tol;
  } ev_t;
  logic CLK = 0, RESET, CFG_VALID, CFG_READY, WR_TR, WR_OVER, IO_UPDATE, BUSY, DONE, ERR;
  logic [3:0] CFG_CHAN;
  logic [2:0] CFG_SEL;
  logic [31:0] CFG_FTW, WR_DATA;
  logic [13:0] CFG_POW;
  logic [9:0] CFG_ASF;
  logic [7:0] WR_ADDR;
  int checks = 0, errors = 0, cyc = 0, lat_lo = 70, lat_hi = 70;
  bit hang = 0;
  ev_t q[$];
  bit in_frame = 0, saw_low = 0, hold_bad = 0, prev_tr = 0;
  logic [7:0] f_addr;
  logic [31:0] f_data;
  int upd_w = 0;

  ad9911_channel_config_seq dut (
    .CLK(CLK), .RESET(RESET), .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY),
    .CFG_CHAN(CFG_CHAN), .CFG_SEL(CFG_SEL), .CFG_FTW(CFG_FTW), .CFG_POW(CFG_POW),
    .CFG_ASF(CFG_ASF), .WR_TR(WR_TR), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .WR_OVER(WR_OVER), .IO_UPDATE(IO_UPDATE), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [7:0] a, input logic [31:0] d, input int when, input int tol);
    q.push_back('{kind, a, d, when, tol});
  endtask

  task automatic take(input int kind, input logic [7:0] a, input logic [31:0] d);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event got kind=%0d addr=%h data=%h cyc=%0d exp none", kind, a, d, cyc);
      return;
    end
    e = q.pop_front();
    if (e.kind != kind || e.addr !== a || e.data !== d ||
        (e.when >= 0 && (cyc > e.when + e.tol || cyc + e.tol < e.when))) begin
      errors++;
      $display("FAIL event got kind=%0d addr=%h data=%h cyc=%0d exp kind=%0d addr=%h data=%h cyc=%0d",
               kind, a, d, cyc, e.kind, e.addr, e.data, e.when);
    end
  endtask

  // reference model: the writes, update pulse and completion a request must produce
  task automatic model(input logic [3:0] ch, input logic [2:0] sel, input logic [31:0] ftw,
                       input logic [13:0] pow, input logic [9:0] asf, input int acc);
    if (ch == 0 || sel == 0) begin
      push_ev(2, 8'h00, 32'd0, acc + 2, 0);
    end else if (hang) begin
      push_ev(0, 8'h00, 32'(ch) * 16, -1, 0);
      push_ev(2, 8'h00, 32'd1, acc + 4 + TIMEOUT, 6);
    end else begin
      push_ev(0, 8'h00, 32'(ch) * 16, -1, 0);
      if (sel[0]) push_ev(0, 8'h04, ftw, -1, 0);
      if (sel[1]) push_ev(0, 8'h05, 32'(pow), -1, 0);
      if (sel[2]) push_ev(0, 8'h06, 32'h1000 + 32'(asf), -1, 0);
      push_ev(1, 8'h00, 32'd4, -1, 0);
      push_ev(2, 8'h00, 32'd0, -1, 0);
    end
  endtask

  task automatic boot_model();
    push_ev(0, 8'h01, 32'h00D00000, -1, 0);
    push_ev(1, 8'h00, 32'd4, -1, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, {31'b0, CFG_READY}, 0);
    chk({tag, "_tr"}, {31'b0, WR_TR}, 0);
    chk({tag, "_addr"}, {24'b0, WR_ADDR}, 0);
    chk({tag, "_data"}, WR_DATA, 0);
    chk({tag, "_ioupd"}, {31'b0, IO_UPDATE}, 0);
    chk({tag, "_busy"}, {31'b0, BUSY}, 1);
    chk({tag, "_done"}, {31'b0, DONE}, 0);
    chk({tag, "_err"}, {31'b0, ERR}, 0);
  endtask

  task automatic send(input logic [3:0] ch, input logic [2:0] sel, input logic [31:0] ftw,
                      input logic [13:0] pow, input logic [9:0] asf, input bit hold_valid);
    int n = 0;
    int acc;
    CFG_CHAN = ch; CFG_SEL = sel; CFG_FTW = ftw; CFG_POW = pow; CFG_ASF = asf; CFG_VALID = 1;
    while (!CFG_READY && n < 5000) begin @(posedge CLK); #1; n++; end
    if (!CFG_READY) begin
      checks++; errors++;
      $display("FAIL ready_wait got=0 exp=1");
      CFG_VALID = 0;
      return;
    end
    acc = cyc;
    @(posedge CLK); #1;
    model(ch, sel, ftw, pow, asf, acc);
    chk("err_clr", {31'b0, ERR}, 0);
    if (hold_valid)
      while (!CFG_READY && n < 5000) begin
        CFG_FTW = $urandom; CFG_CHAN = 4'($urandom); CFG_SEL = 3'($urandom);
        CFG_POW = 14'($urandom); CFG_ASF = 10'($urandom);
        @(posedge CLK); #1; n++;
      end
    CFG_VALID = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(CFG_READY && q.size() == 0) && n < 5000) begin @(posedge CLK); #1; n++; end
    chk({name, "_idle"}, {31'b0, CFG_READY && q.size() == 0}, 1);
  endtask

  // writer model: goes busy a cycle after TR, stays busy for a random time; in hang mode it never answers
  initial begin
    WR_OVER = 1;
    forever begin
      @(posedge CLK); #1;
      if (WR_TR && !hang && !RESET) begin
        @(posedge CLK); #1 WR_OVER = 0;
        repeat ($urandom_range(lat_hi, lat_lo)) @(posedge CLK);
        #1 WR_OVER = 1;
      end
    end
  end

  // monitor: pops the scoreboard on every write strobe, IO_UPDATE pulse end and DONE pulse
  always @(negedge CLK) begin
    if (RESET) begin
      in_frame = 0; upd_w = 0; prev_tr = 0;
    end else begin
      if (WR_TR) begin
        chk("tr_while_busy", {31'b0, WR_OVER}, 1);
        chk("tr_width", {31'b0, prev_tr}, 0);
        in_frame = 1; saw_low = 0; hold_bad = 0; f_addr = WR_ADDR; f_data = WR_DATA;
        take(0, WR_ADDR, WR_DATA);
      end else if (in_frame) begin
        if (WR_ADDR !== f_addr || WR_DATA !== f_data) hold_bad = 1;
        if (!WR_OVER) saw_low = 1;
        else if (saw_low) begin
          in_frame = 0;
          chk("data_hold", {31'b0, hold_bad}, 0);
        end
      end
      if (IO_UPDATE) upd_w++;
      else if (upd_w != 0) begin
        take(1, 8'h00, 32'(upd_w));
        upd_w = 0;
      end
      if (DONE) take(2, 8'h00, {31'b0, ERR});
      prev_tr = WR_TR;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RESET = 1; CFG_VALID = 0; CFG_CHAN = 0; CFG_SEL = 0; CFG_FTW = 0; CFG_POW = 0; CFG_ASF = 0;
    repeat (3) @(posedge CLK); #1;
    chk_reset("rst");
    boot_model();
    RESET = 0;
    wait_idle("boot");
    lat_lo = 2; lat_hi = 15;
    send(4'b0001, 3'b001, 32'h051EB852, 14'h0, 10'h0, 0);
    wait_idle("ftw_only");
    send(4'b1111, 3'b111, 32'hDEADBEEF, 14'h2000, 10'h3FF, 0);
    wait_idle("all_regs");
    hang = 1;
    send(4'b0011, 3'b111, 32'h12345678, 14'h0123, 10'h155, 0);
    wait_idle("hang");
    chk("err_sticky", {31'b0, ERR}, 1);
    hang = 0;
    send(4'b0100, 3'b010, 32'h0, 14'h1ABC, 10'h0, 0);
    wait_idle("after_hang");
    send(4'b1000, 3'b101, 32'hCAFEF00D, 14'h0, 10'h2AA, 1);
    wait_idle("hold_valid");
    send(4'b1010, 3'b000, 32'h11111111, 14'h1, 10'h1, 0);
    wait_idle("sel_zero");
    send(4'b0000, 3'b111, 32'h22222222, 14'h2, 10'h2, 0);
    wait_idle("chan_zero");
    for (int i = 0; i < 16; i++) begin
      lat_lo = 1; lat_hi = 12;
      send(4'($urandom), 3'($urandom), $urandom, 14'($urandom), 10'($urandom), 0);
      wait_idle("rand");
    end
    lat_lo = 40; lat_hi = 40;
    send(4'b0001, 3'b001, 32'h0BADF00D, 14'h0, 10'h0, 0);
    n = 0;
    while (!(WR_TR && WR_ADDR == 8'h04) && n < 500) begin @(posedge CLK); #1; n++; end
    chk("ctw0_seen", {31'b0, WR_TR && WR_ADDR == 8'h04}, 1);
    repeat (20) @(posedge CLK);
    #1;
    lat_lo = 3; lat_hi = 8;
    RESET = 1;
    q.delete();
    boot_model();
    @(posedge CLK); #1;
    chk_reset("midrst");
    RESET = 0;
    wait_idle("reboot");
    send(4'b0110, 3'b011, 32'h76543210, 14'h3FFF, 10'h0, 0);
    wait_idle("post_reboot");
    chk("q_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
